commit_stage_nport: RTL and testbench



---
 rtl/commit_stage_nport_pkg.sv | 59 +++++
 rtl/commit_drain_fsm.sv | 82 ++++++++
 rtl/commit_stage_nport.sv | 162 ++++++++++++++++
 tb/tb_commit_stage_nport.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_stage_nport_pkg.sv
// Shared types for the N-port commit stage: scoreboard entry, FU/op codes, drain FSM states.
package commit_stage_nport_pkg;

    localparam int unsigned XLEN = 64;

    typedef enum logic [3:0] {
        NONE = 4'd0, LOAD = 4'd1, STORE = 4'd2, ALU = 4'd3, CTRL_FLOW = 4'd4,
        MULT = 4'd5, CSR = 4'd6, FPU = 4'd7, FPU_VEC = 4'd8, ACCEL = 4'd9
    } fu_t;

    typedef enum logic [3:0] {
        ADD, SUB, FENCE, FENCE_I, SFENCE_VMA, CSR_WRITE, CSR_READ, CSR_SET, CSR_CLEAR,
        AMO_LRW, AMO_SCW, AMO_SWAPW, AMO_ADDW
    } fu_op;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic            ack;
        logic [XLEN-1:0] result;
    } amo_resp_t;

    typedef struct packed {
        logic            valid;
        fu_t             fu;
        fu_op            op;
        logic [4:0]      rd;
        logic            rd_fpr;
        logic [XLEN-1:0] result;
        exception_t      ex;
    } scoreboard_entry_t;

    typedef enum logic [1:0] {
        COMMIT_IDLE     = 2'd0,
        COMMIT_DRAIN    = 2'd1,
        COMMIT_AMO_WAIT = 2'd2
    } commit_state_e;

    // Indexed by fu_t: LOAD, ALU, CTRL_FLOW, MULT, FPU, FPU_VEC may retire on ports > 0
    localparam logic [15:0] COMMIT_FU_MASK = 16'h01BA;

    function automatic logic is_fence_class(fu_op op);
        return op inside {FENCE, FENCE_I, SFENCE_VMA};
    endfunction

    function automatic logic is_amo(fu_op op);
        return op inside {AMO_LRW, AMO_SCW, AMO_SWAPW, AMO_ADDW};
    endfunction

    // Anything that must be the last retirement of its cycle
    function automatic logic is_serialising(scoreboard_entry_t e);
        return (e.fu == CSR) || (e.fu == STORE) || is_fence_class(e.op) || is_amo(e.op);
    endfunction

endpackage

// File: rtl/commit_drain_fsm.sv
// Fence/AMO sequencing FSM for the head entry plus a saturating drain watchdog.
module commit_drain_fsm
    import commit_stage_nport_pkg::*;
#(
    parameter int unsigned DrainTimeout = 1024
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          halt_i,
    input  logic          flush_i,
    input  logic          fence_req_i,
    input  logic          amo_req_i,
    input  logic          no_st_pending_i,
    input  logic          amo_ack_i,
    output commit_state_e state_o,
    output logic          fence_go_o,
    output logic          amo_go_o,
    output logic          drain_timeout_o
);

    localparam int unsigned WdW = (DrainTimeout > 2) ? $clog2(DrainTimeout) : 1;
    localparam logic [WdW-1:0] WdMax = WdW'(DrainTimeout - 1);

    commit_state_e  state_q, state_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic           timeout_q, timeout_d;

    always_comb begin
        state_d    = state_q;
        fence_go_o = 1'b0;
        amo_go_o   = 1'b0;
        case (state_q)
            COMMIT_IDLE: begin
                if (!halt_i) begin
                    if (fence_req_i) begin
                        if (no_st_pending_i) fence_go_o = 1'b1;
                        else                 state_d    = COMMIT_DRAIN;
                    end else if (amo_req_i) begin
                        if (amo_ack_i) amo_go_o = 1'b1;
                        else           state_d  = COMMIT_AMO_WAIT;
                    end
                end
            end
            COMMIT_DRAIN: begin
                if (!halt_i && no_st_pending_i) begin
                    fence_go_o = 1'b1;
                    state_d    = COMMIT_IDLE;
                end
            end
            COMMIT_AMO_WAIT: begin
                if (!halt_i && amo_ack_i) begin
                    amo_go_o = 1'b1;
                    state_d  = COMMIT_IDLE;
                end
            end
            default: state_d = COMMIT_IDLE;
        endcase
        if (flush_i) state_d = COMMIT_IDLE;

        // Counter holds the number of completed busy cycles; pulse registers the step onto WdMax
        wd_d = '0;
        if (state_d != COMMIT_IDLE && state_q != COMMIT_IDLE)
            wd_d = (wd_q == WdMax) ? wd_q : wd_q + 1'b1;
        timeout_d = (wd_d == WdMax) && (wd_q != WdMax) && (state_d != COMMIT_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= COMMIT_IDLE;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign state_o         = state_q;
    assign drain_timeout_o = timeout_q;

endmodule

// File: rtl/commit_stage_nport.sv
// Multi-port in-order commit: retires up to NrCommitPorts head entries per cycle,
// sequencing fences and AMOs through commit_drain_fsm.
module commit_stage_nport
    import commit_stage_nport_pkg::*;
#(
    parameter int unsigned NrCommitPorts = 2,
    parameter int unsigned DrainTimeout  = 1024,
    parameter int unsigned CntW          = $clog2(NrCommitPorts + 1)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    halt_i,
    input  logic                                    flush_i,
    input  logic                                    single_step_i,
    input  logic                                    flush_dcache_i,
    input  scoreboard_entry_t [NrCommitPorts-1:0]   commit_instr_i,
    output logic [NrCommitPorts-1:0]                commit_ack_o,
    output logic [NrCommitPorts-1:0][4:0]           waddr_o,
    output logic [NrCommitPorts-1:0][XLEN-1:0]      wdata_o,
    output logic [NrCommitPorts-1:0]                we_gpr_o,
    output logic [NrCommitPorts-1:0]                we_fpr_o,
    input  amo_resp_t                               amo_resp_i,
    output logic                                    amo_valid_commit_o,
    output fu_op                                    csr_op_o,
    output logic [XLEN-1:0]                         csr_wdata_o,
    output logic                                    csr_write_fflags_o,
    output logic                                    commit_csr_o,
    input  logic [XLEN-1:0]                         csr_rdata_i,
    input  exception_t                              csr_exception_i,
    output logic                                    commit_lsu_o,
    input  logic                                    commit_lsu_ready_i,
    input  logic                                    no_st_pending_i,
    output logic                                    commit_acc_o,
    output logic                                    fence_o,
    output logic                                    fence_i_o,
    output logic                                    sfence_vma_o,
    output logic                                    flush_commit_o,
    output exception_t                              exception_o,
    output logic [CntW-1:0]                         commit_cnt_o,
    output logic [63:0]                             instret_o,
    output logic                                    drain_timeout_o,
    output logic [1:0]                              state_o
);

    scoreboard_entry_t       e0;
    commit_state_e           state;
    logic                    v0, amo0, fence0, store0, csr0, idle;
    logic                    fence_go, amo_go;
    logic [NrCommitPorts-1:0] ack, blk;
    logic [4:0]              fflags;
    logic                    any_fp;
    logic [CntW-1:0]         pop;
    logic [CntW-1:0]         cnt_q;
    logic [63:0]             instret_q;

    assign e0     = commit_instr_i[0];
    assign idle   = (state == COMMIT_IDLE);
    assign v0     = e0.valid && !e0.ex.valid && !halt_i;
    assign amo0   = (e0.fu == STORE) && is_amo(e0.op);
    assign fence0 = v0 && (is_fence_class(e0.op) || (flush_dcache_i && e0.fu != STORE));
    assign store0 = (e0.fu == STORE) && !amo0;
    assign csr0   = (e0.fu == CSR) && !is_fence_class(e0.op) && !fence0;

    commit_drain_fsm #(.DrainTimeout(DrainTimeout)) u_drain (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .halt_i          (halt_i),
        .flush_i         (flush_i),
        .fence_req_i     (fence0),
        .amo_req_i       (v0 && amo0),
        .no_st_pending_i (no_st_pending_i),
        .amo_ack_i       (amo_resp_i.ack),
        .state_o         (state),
        .fence_go_o      (fence_go),
        .amo_go_o        (amo_go),
        .drain_timeout_o (drain_timeout_o)
    );

    always_comb begin
        ack    = '0;
        blk    = '0;
        ack[0] = v0 && (fence0 ? fence_go :
                        amo0   ? amo_go   :
                        idle && (store0 ? commit_lsu_ready_i :
                                 csr0   ? !csr_exception_i.valid : 1'b1));
        for (int i = 1; i < NrCommitPorts; i++) begin
            blk[i] = blk[i-1] || is_serialising(commit_instr_i[i-1]);
            ack[i] = ack[i-1] && idle && !single_step_i && !flush_dcache_i && !halt_i
                     && !blk[i] && COMMIT_FU_MASK[commit_instr_i[i].fu]
                     && commit_instr_i[i].valid && !commit_instr_i[i].ex.valid;
        end
    end

    always_comb begin
        waddr_o  = '0;
        wdata_o  = '0;
        we_gpr_o = '0;
        we_fpr_o = '0;
        fflags   = '0;
        any_fp   = 1'b0;
        pop      = '0;
        for (int i = 0; i < NrCommitPorts; i++) begin
            if (ack[i]) begin
                waddr_o[i]  = commit_instr_i[i].rd;
                wdata_o[i]  = commit_instr_i[i].result;
                we_gpr_o[i] = !commit_instr_i[i].rd_fpr;
                we_fpr_o[i] = commit_instr_i[i].rd_fpr;
                if (commit_instr_i[i].fu inside {FPU, FPU_VEC}) begin
                    fflags = fflags | commit_instr_i[i].ex.cause[4:0];
                    any_fp = 1'b1;
                end
            end
            pop = pop + CntW'(ack[i]);
        end
        if (ack[0] && csr0) wdata_o[0] = csr_rdata_i;
        if (ack[0] && amo0) wdata_o[0] = amo_resp_i.result;
    end

    assign commit_ack_o       = ack;
    assign amo_valid_commit_o = e0.valid && amo0;
    assign csr_op_o           = (v0 && idle && csr0) ? e0.op : ADD;
    assign csr_wdata_o        = ((v0 && idle && csr0) ? e0.result : '0) | XLEN'(fflags);
    assign csr_write_fflags_o = any_fp;
    assign commit_csr_o       = ack[0] && csr0;
    assign commit_lsu_o       = v0 && idle && store0;
    assign commit_acc_o       = !e0.valid && (e0.fu == ACCEL);
    // flush_dcache_i reclassifies whatever sits at port 0 as a FENCE_I
    assign fence_o            = ack[0] && fence0 && !flush_dcache_i && (e0.op == FENCE);
    assign fence_i_o          = ack[0] && fence0 && (flush_dcache_i || e0.op == FENCE_I);
    assign sfence_vma_o       = ack[0] && fence0 && !flush_dcache_i && (e0.op == SFENCE_VMA);
    assign flush_commit_o     = ack[0] && amo0;
    assign state_o            = state;

    always_comb begin
        exception_o = '0;
        if (e0.valid && !halt_i) begin
            if (e0.ex.valid) begin
                exception_o = e0.ex;
            end else if (csr0 && csr_exception_i.valid) begin
                exception_o      = csr_exception_i;
                exception_o.tval = e0.ex.tval;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            instret_q <= '0;
        end else begin
            cnt_q     <= pop;
            instret_q <= instret_q + 64'(pop);
        end
    end

    assign commit_cnt_o = cnt_q;
    assign instret_o    = instret_q;

    logic unused_bits;
    assign unused_bits = ^{commit_instr_i, csr_exception_i, blk};

endmodule

// File: tb/tb_commit_stage_nport.sv
// Directed bench for commit_stage_nport (4 ports, 8-cycle drain timeout).
module tb_commit_stage_nport;
    import commit_stage_nport_pkg::*;

    localparam int N = 4;

    logic clk_i = 1'b0;
    logic rst_ni, halt_i, flush_i, single_step_i, flush_dcache_i;
    scoreboard_entry_t [N-1:0] commit_instr_i;
    logic [N-1:0] commit_ack_o, we_gpr_o, we_fpr_o;
    logic [N-1:0][4:0] waddr_o;
    logic [N-1:0][63:0] wdata_o;
    amo_resp_t amo_resp_i;
    logic amo_valid_commit_o, csr_write_fflags_o, commit_csr_o;
    fu_op csr_op_o;
    logic [63:0] csr_wdata_o, csr_rdata_i, instret_o;
    exception_t csr_exception_i, exception_o;
    logic commit_lsu_o, commit_lsu_ready_i, no_st_pending_i, commit_acc_o;
    logic fence_o, fence_i_o, sfence_vma_o, flush_commit_o, drain_timeout_o;
    logic [2:0] commit_cnt_o;
    logic [1:0] state_o;

    always #5 clk_i = ~clk_i;

    commit_stage_nport #(.NrCommitPorts(N), .DrainTimeout(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .halt_i(halt_i), .flush_i(flush_i),
        .single_step_i(single_step_i), .flush_dcache_i(flush_dcache_i),
        .commit_instr_i(commit_instr_i), .commit_ack_o(commit_ack_o),
        .waddr_o(waddr_o), .wdata_o(wdata_o), .we_gpr_o(we_gpr_o), .we_fpr_o(we_fpr_o),
        .amo_resp_i(amo_resp_i), .amo_valid_commit_o(amo_valid_commit_o),
        .csr_op_o(csr_op_o), .csr_wdata_o(csr_wdata_o), .csr_write_fflags_o(csr_write_fflags_o),
        .commit_csr_o(commit_csr_o), .csr_rdata_i(csr_rdata_i), .csr_exception_i(csr_exception_i),
        .commit_lsu_o(commit_lsu_o), .commit_lsu_ready_i(commit_lsu_ready_i),
        .no_st_pending_i(no_st_pending_i), .commit_acc_o(commit_acc_o),
        .fence_o(fence_o), .fence_i_o(fence_i_o), .sfence_vma_o(sfence_vma_o),
        .flush_commit_o(flush_commit_o), .exception_o(exception_o),
        .commit_cnt_o(commit_cnt_o), .instret_o(instret_o),
        .drain_timeout_o(drain_timeout_o), .state_o(state_o)
    );

    int checks = 0;
    int errors = 0;
    longint unsigned model_instret = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic scoreboard_entry_t ent(fu_t fu, fu_op op, logic v, logic exv,
                                              logic [4:0] cause, logic [4:0] rd);
        scoreboard_entry_t e;
        e          = '0;
        e.valid    = v;
        e.fu       = fu;
        e.op       = op;
        e.rd       = rd;
        e.result   = 64'(rd) << 8;
        e.ex.valid = exv;
        e.ex.cause = 64'(cause);
        e.ex.tval  = 64'hBAD0;
        return e;
    endfunction

    typedef struct {
        string                     name;
        scoreboard_entry_t [N-1:0] ins;
        logic [3:0]                ctl;   // {halt, flush_dcache, single_step, lsu_ready}
        logic [N-1:0]              ack;
        logic [4:0]                ff;
        logic                      wff;
        logic [2:0]                pulse; // {fence, fence_i, sfence_vma}
        logic                      exc;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(string nm, scoreboard_entry_t p0, scoreboard_entry_t p1,
                                scoreboard_entry_t p2, scoreboard_entry_t p3, logic [3:0] ctl,
                                logic [N-1:0] ack, logic [4:0] ff, logic wff, logic [2:0] pulse,
                                logic exc);
        vec_t v;
        v.name = nm;
        v.ins  = {p3, p2, p1, p0};
        v.ctl  = ctl; v.ack = ack; v.ff = ff; v.wff = wff; v.pulse = pulse; v.exc = exc;
        return v;
    endfunction

    scoreboard_entry_t A, S, C, FN, SF, X, I, F1, F16, L, M, B, FV, AM;

    initial begin
        A   = ent(ALU, ADD, 1, 0, 5'd0, 5'd1);
        S   = ent(STORE, ADD, 1, 0, 5'd0, 5'd0);
        C   = ent(CSR, CSR_WRITE, 1, 0, 5'd0, 5'd0);
        FN  = ent(CSR, FENCE, 1, 0, 5'd0, 5'd0);
        SF  = ent(CSR, SFENCE_VMA, 1, 0, 5'd0, 5'd0);
        X   = ent(ALU, ADD, 1, 1, 5'd2, 5'd3);
        I   = ent(ALU, ADD, 0, 0, 5'd0, 5'd4);
        F1  = ent(FPU, ADD, 1, 0, 5'b00001, 5'd5);
        F16 = ent(FPU, ADD, 1, 0, 5'b10000, 5'd6);
        L   = ent(LOAD, ADD, 1, 0, 5'd0, 5'd7);
        M   = ent(MULT, ADD, 1, 0, 5'd0, 5'd8);
        B   = ent(CTRL_FLOW, ADD, 1, 0, 5'd0, 5'd9);
        FV  = ent(FPU_VEC, ADD, 1, 0, 5'b00100, 5'd10);
        AM  = ent(STORE, AMO_ADDW, 1, 0, 5'd0, 5'd11);

        vt.push_back(mk("4alu",    A,  A,   A, A,   4'b0001, 4'b1111, 5'h00, 0, 3'b000, 0));
        vt.push_back(mk("store1",  A,  S,   A, A,   4'b0001, 4'b0001, 5'h00, 0, 3'b000, 0));
        vt.push_back(mk("st_nrdy", S,  A,   A, A,   4'b0000, 4'b0000, 5'h00, 0, 3'b000, 0));
        vt.push_back(mk("st_rdy",  S,  A,   A, A,   4'b0001, 4'b0001, 5'h00, 0, 3'b000, 0));
        vt.push_back(mk("fflags",  F1, F16, A, A,   4'b0001, 4'b1111, 5'h11, 1, 3'b000, 0));
        vt.push_back(mk("inv1",    A,  I,   A, A,   4'b0001, 4'b0001, 5'h00, 0, 3'b000, 0));
        vt.push_back(mk("exv1",    A,  X,   A, A,   4'b0001, 4'b0001, 5'h00, 0, 3'b000, 0));
        vt.push_back(mk("sstep",   A,  A,   A, A,   4'b0011, 4'b0001, 5'h00, 0, 3'b000, 0));
        vt.push_back(mk("halt",    A,  A,   A, A,   4'b1001, 4'b0000, 5'h00, 0, 3'b000, 0));
        vt.push_back(mk("fence",   FN, A,   A, A,   4'b0001, 4'b0001, 5'h00, 0, 3'b100, 0));
        vt.push_back(mk("csr",     C,  A,   A, A,   4'b0001, 4'b0001, 5'h00, 0, 3'b000, 0));
        vt.push_back(mk("exc0",    X,  A,   A, A,   4'b0001, 4'b0000, 5'h00, 0, 3'b000, 1));
        vt.push_back(mk("none",    I,  I,   I, I,   4'b0001, 4'b0000, 5'h00, 0, 3'b000, 0));
        vt.push_back(mk("mix",     L,  M,   B, FV,  4'b0001, 4'b1111, 5'h04, 1, 3'b000, 0));
        vt.push_back(mk("fdc",     A,  A,   A, A,   4'b0101, 4'b0001, 5'h00, 0, 3'b010, 0));
        vt.push_back(mk("sfence",  SF, A,   A, A,   4'b0001, 4'b0001, 5'h00, 0, 3'b001, 0));
        vt.push_back(mk("fpu_gap", F1, A,   S, F16, 4'b0001, 4'b0011, 5'h01, 1, 3'b000, 0));

        rst_ni = 1'b0; halt_i = 1'b0; flush_i = 1'b0; single_step_i = 1'b0;
        flush_dcache_i = 1'b0; commit_instr_i = {I, I, I, I}; amo_resp_i = '0;
        csr_rdata_i = '0; csr_exception_i = '0; commit_lsu_ready_i = 1'b1;
        no_st_pending_i = 1'b1;
        #1;
        chk("rst_state",   64'(state_o), 64'(0));
        chk("rst_instret", instret_o, 64'(0));
        chk("rst_cnt",     64'(commit_cnt_o), 64'(0));
        chk("rst_timeout", 64'(drain_timeout_o), 64'(0));
        chk("rst_csr_op",  64'(csr_op_o), 64'(ADD));
        chk("rst_ack",     64'(commit_ack_o), 64'(0));
        @(negedge clk_i); @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (vt[k]) begin
            @(negedge clk_i);
            commit_instr_i     = vt[k].ins;
            {halt_i, flush_dcache_i, single_step_i, commit_lsu_ready_i} = vt[k].ctl;
            #1;
            chk({vt[k].name, "_ack"},   64'(commit_ack_o), 64'(vt[k].ack));
            chk({vt[k].name, "_gpr"},   64'(we_gpr_o), 64'(vt[k].ack));
            chk({vt[k].name, "_fflag"}, csr_wdata_o, 64'(vt[k].ff));
            chk({vt[k].name, "_wff"},   64'(csr_write_fflags_o), 64'(vt[k].wff));
            chk({vt[k].name, "_pulse"}, 64'({fence_o, fence_i_o, sfence_vma_o}), 64'(vt[k].pulse));
            chk({vt[k].name, "_exc"},   64'(exception_o.valid), 64'(vt[k].exc));
            model_instret += 64'($countones(vt[k].ack));
            @(posedge clk_i); #1;
            chk({vt[k].name, "_cnt"},     64'(commit_cnt_o), 64'($countones(vt[k].ack)));
            chk({vt[k].name, "_instret"}, instret_o, model_instret);
        end
        halt_i = 1'b0; flush_dcache_i = 1'b0; single_step_i = 1'b0; commit_lsu_ready_i = 1'b1;

        // CSR write-back and CSR exception
        @(negedge clk_i);
        commit_instr_i = {I, I, A, C}; csr_rdata_i = 64'hCAFE; #1;
        chk("csr_ack",   64'(commit_ack_o), 64'b0001);
        chk("csr_wdata", wdata_o[0], 64'hCAFE);
        chk("csr_commit", 64'(commit_csr_o), 64'(1));
        chk("csr_op",    64'(csr_op_o), 64'(CSR_WRITE));
        model_instret += 1;
        @(negedge clk_i);
        csr_exception_i.valid = 1'b1; csr_exception_i.cause = 64'd5; #1;
        chk("csrx_ack",   64'(commit_ack_o), 64'(0));
        chk("csrx_valid", 64'(exception_o.valid), 64'(1));
        chk("csrx_tval",  exception_o.tval, 64'hBAD0);
        chk("csrx_cause", exception_o.cause, 64'd5);
        @(negedge clk_i);
        csr_exception_i = '0; commit_instr_i = {I, I, I, I};

        // Fence drain with a one-cycle halt
        @(negedge clk_i);
        commit_instr_i = {I, I, I, FN}; no_st_pending_i = 1'b0; #1;
        chk("fA_idle_ack", 64'(commit_ack_o), 64'(0));
        chk("fA_idle_st",  64'(state_o), 64'(0));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i); #1;
            chk("fA_state", 64'(state_o), 64'(1));
            chk("fA_noack", 64'(commit_ack_o), 64'(0));
            chk("fA_nofence", 64'(fence_o), 64'(0));
        end
        @(negedge clk_i);
        no_st_pending_i = 1'b1; halt_i = 1'b1; #1;
        chk("fA_halt_ack",   64'(commit_ack_o), 64'(0));
        chk("fA_halt_fence", 64'(fence_o), 64'(0));
        @(negedge clk_i);
        halt_i = 1'b0; #1;
        chk("fA_hold_state", 64'(state_o), 64'(1));
        chk("fA_fence", 64'(fence_o), 64'(1));
        chk("fA_ack",   64'(commit_ack_o), 64'b0001);
        model_instret += 1;
        @(posedge clk_i); #1;
        chk("fA_cnt", 64'(commit_cnt_o), 64'(1));
        @(negedge clk_i);
        commit_instr_i = {I, I, I, I}; #1;
        chk("fA_back_idle", 64'(state_o), 64'(0));

        // AMO: response arrives after five waiting cycles
        begin
            int hi;
            hi = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk_i);
                commit_instr_i = {I, I, I, AM};
                amo_resp_i.result = 64'hDEAD_BEEF_0123_4567;
                amo_resp_i.ack = (k == 5); #1;
                if (amo_valid_commit_o) hi++;
                if (k < 5) chk("amo_wait_ack", 64'(commit_ack_o), 64'(0));
            end
            chk("amo_state",  64'(state_o), 64'(2));
            chk("amo_ack",    64'(commit_ack_o), 64'b0001);
            chk("amo_flush",  64'(flush_commit_o), 64'(1));
            chk("amo_we",     64'(we_gpr_o[0]), 64'(1));
            chk("amo_wdata",  wdata_o[0], 64'hDEAD_BEEF_0123_4567);
            chk("amo_vcycles", 64'(hi), 64'(6));
            model_instret += 1;
            @(negedge clk_i);
            commit_instr_i = {I, I, I, I}; amo_resp_i = '0; #1;
            chk("amo_idle", 64'(state_o), 64'(0));
        end

        // Watchdog: single pulse in the 8th drain cycle, cleared by flush
        begin
            int pulses;
            pulses = 0;
            @(negedge clk_i);
            commit_instr_i = {I, I, I, FN}; no_st_pending_i = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk_i); #1;
                if (drain_timeout_o) pulses++;
                chk("wd_state", 64'(state_o), 64'(1));
                chk("wd_pulse", 64'(drain_timeout_o), 64'(k == 8));
            end
            chk("wd_once", 64'(pulses), 64'(1));
            flush_i = 1'b1;
            @(negedge clk_i);
            flush_i = 1'b0; #1;
            chk("wd_flush_idle", 64'(state_o), 64'(0));
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk_i); #1;
                chk("wd2_pulse", 64'(drain_timeout_o), 64'(k == 8));
            end
        end
        chk("instret_total", instret_o, model_instret);

        // Asynchronous reset in the middle of a drain
        #2 rst_ni = 1'b0; #1;
        chk("arst_state",   64'(state_o), 64'(0));
        chk("arst_instret", instret_o, 64'(0));
        chk("arst_cnt",     64'(commit_cnt_o), 64'(0));
        chk("arst_pulses",  64'({drain_timeout_o, fence_o, fence_i_o, sfence_vma_o, flush_commit_o}), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
